// File: rtl/program_loader.sv
// program_loader: boot-stage image loader for the single-cycle processor.
// Takes a byte stream (valid/ready), builds big-endian 32-bit words, writes
// them to instruction memory and checks an XOR checksum. The processor stays
// in start-up until the image is loaded and has passed the checksum.
//
// Ports:
//   clk, start_up_n          clock, async active-low reset
//   byte_valid, byte_data    incoming stream byte
//   byte_ready               loader can accept a byte (combinational from state)
//   imem_we/addr/wdata       one-cycle instruction memory write
//   proc_start_up            1 = hold processor PC in reset
//   load_done, load_error    sticky completion / failure flags
//   word_count               words written so far
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        start_up_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        proc_start_up,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] word_count
);

    localparam logic [2:0] S_HDR_HI  = 3'd0;
    localparam logic [2:0] S_HDR_LO  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] wc_q, wc_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        ready_c;
    logic        accept_c;
    logic [15:0] hdr_len_c;

    // Ready in every state that still consumes stream bytes.
    assign ready_c    = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign byte_ready = ready_c & start_up_n;
    assign accept_c   = byte_valid & ready_c;
    assign hdr_len_c  = {n_q[15:8], byte_data};

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        word_d  = word_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wc_d    = wc_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_HDR_HI: begin
                if (accept_c) begin
                    n_d[15:8] = byte_data;
                    state_d   = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept_c) begin
                    n_d = hdr_len_c;
                    if (32'(hdr_len_c) > MAX_WORDS) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (hdr_len_c == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept_c) begin
                    word_d = {word_q[15:0], byte_data};
                    csum_d = csum_q ^ byte_data;
                    idx_d  = idx_q + 2'd1;
                    // Fourth byte completes a word: issue its write and count it.
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + 32'({wc_q, 2'b00});
                        wdata_d = {word_q, byte_data};
                        wc_d    = wc_q + 16'd1;
                        if ((wc_q + 16'd1) == n_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (accept_c) begin
                    if (byte_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge start_up_n) begin
        if (!start_up_n) begin
            state_q <= S_HDR_HI;
            n_q     <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            wc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wc_q    <= wc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign load_done     = done_q;
    assign load_error    = err_q;
    assign proc_start_up = ~done_q;
    assign word_count    = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        start_up_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        proc_start_up;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic        prev_we = 1'b0;
    int          consec_we = 0;
    logic [7:0]  stm [0:15];

    program_loader dut (
        .clk           (clk),
        .start_up_n    (start_up_n),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .proc_start_up (proc_start_up),
        .load_done     (load_done),
        .load_error    (load_error),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    // Record every write strobe; a strobe spans exactly one negedge.
    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            if (prev_we) consec_we++;
        end
        prev_we = imem_we;
    end

    task automatic load_stream(input logic [7:0] cs);
        stm[0] = 8'h00; stm[1] = 8'h02;
        stm[2] = 8'h20; stm[3] = 8'h08; stm[4]  = 8'h00; stm[5] = 8'h05;
        stm[6] = 8'h01; stm[7] = 8'h09; stm[8]  = 8'h50; stm[9] = 8'h20;
        stm[10] = cs;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start_up_n = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        start_up_n = 1'b1;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int w;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        w = 0;
        while (!byte_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!byte_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout byte=%h ready=%b wanted 1", b, byte_ready);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_seq(input int n, input bit gaps);
        for (int i = 0; i < n; i++) send_byte(stm[i], gaps);
    endtask

    task automatic test_reset();
        do_reset();
        load_stream(8'h55);
        send_seq(6, 1'b0);
        @(posedge clk);
        #3;
        start_up_n = 1'b0;
        #1;
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", byte_ready); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", imem_we); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata); end
        total++; if (proc_start_up !== 1'b1) begin bad++; $display("FAIL rst_psu got=%b exp=1", proc_start_up); end
        total++; if (load_done !== 1'b0 || load_error !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", load_done, load_error); end
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL rst_wc got=%0d exp=0", word_count); end
        #20;
        start_up_n = 1'b1;
    endtask

    task automatic test_load_ok();
        do_reset();
        load_stream(8'h55);
        send_seq(10, 1'b0);
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL ok_done_early got=%b exp=0", load_done); end
        send_byte(stm[10], 1'b0);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL ok_done got=%b exp=1", load_done); end
        total++; if (proc_start_up !== 1'b0) begin bad++; $display("FAIL ok_psu got=%b exp=0", proc_start_up); end
        total++; if (load_error !== 1'b0) begin bad++; $display("FAIL ok_err got=%b exp=0", load_error); end
        total++; if (word_count !== 16'd2) begin bad++; $display("FAIL ok_wc got=%0d exp=2", word_count); end
        @(negedge clk);
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL ok_ready got=%b exp=0", byte_ready); end
        total++;
        if (wa_q.size() != 2) begin bad++; $display("FAIL ok_nwrites got=%0d exp=2", wa_q.size()); end
        else if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h2008_0005 || wa_q[1] !== 32'h4 || wd_q[1] !== 32'h0109_5020) begin
            bad++;
            $display("FAIL ok_writes got=(%h,%h)(%h,%h) exp=(0,20080005)(4,01095020)", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        load_stream(8'hAA);
        send_seq(11, 1'b0);
        total++; if (load_error !== 1'b1) begin bad++; $display("FAIL bad_err got=%b exp=1", load_error); end
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL bad_done got=%b exp=0", load_done); end
        total++; if (proc_start_up !== 1'b1) begin bad++; $display("FAIL bad_psu got=%b exp=1", proc_start_up); end
        @(negedge clk);
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL bad_ready got=%b exp=0", byte_ready); end
        total++; if (wa_q.size() != 2) begin bad++; $display("FAIL bad_nwrites got=%0d exp=2", wa_q.size()); end
    endtask

    task automatic test_zero_len();
        do_reset();
        stm[0] = 8'h00; stm[1] = 8'h00; stm[2] = 8'h00;
        send_seq(3, 1'b0);
        @(negedge clk);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", load_done); end
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL zero_wc got=%0d exp=0", word_count); end
        total++; if (wa_q.size() != 0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", wa_q.size()); end
    endtask

    task automatic test_too_long();
        do_reset();
        stm[0] = 8'h01; stm[1] = 8'h01;
        send_seq(2, 1'b0);
        total++; if (load_error !== 1'b1) begin bad++; $display("FAIL long_err got=%b exp=1", load_error); end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL long_ready got=%b exp=0", byte_ready); end
        end
        byte_valid = 1'b0;
        total++; if (load_done !== 1'b0 || proc_start_up !== 1'b1) begin bad++; $display("FAIL long_flags got=%b%b exp=01", load_done, proc_start_up); end
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL long_wc got=%0d exp=0", word_count); end
    endtask

    task automatic test_gaps_abort();
        do_reset();
        load_stream(8'h55);
        send_seq(8, 1'b1);
        repeat (3) @(negedge clk);
        total++; if (wa_q.size() != 1) begin bad++; $display("FAIL abort_pre_nwrites got=%0d exp=1", wa_q.size()); end
        else if (wd_q[0] !== 32'h2008_0005) begin bad++; $display("FAIL abort_pre_word got=%h exp=20080005", wd_q[0]); end
        #2;
        start_up_n = 1'b0;
        #1;
        total++; if (word_count !== 16'd0 || imem_we !== 1'b0) begin bad++; $display("FAIL abort_rst got wc=%0d we=%b exp wc=0 we=0", word_count, imem_we); end
        repeat (2) @(negedge clk);
        start_up_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (wa_q.size() != 1) begin bad++; $display("FAIL abort_partial got=%0d exp=1", wa_q.size()); end
        wa_q.delete();
        wd_q.delete();
        send_seq(11, 1'b1);
        repeat (2) @(negedge clk);
        total++; if (load_done !== 1'b1 || word_count !== 16'd2) begin bad++; $display("FAIL replay_done got done=%b wc=%0d exp done=1 wc=2", load_done, word_count); end
        total++;
        if (wa_q.size() != 2) begin bad++; $display("FAIL replay_nwrites got=%0d exp=2", wa_q.size()); end
        else if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h2008_0005 || wa_q[1] !== 32'h4 || wd_q[1] !== 32'h0109_5020) begin
            bad++;
            $display("FAIL replay_writes got=(%h,%h)(%h,%h) exp=(0,20080005)(4,01095020)", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        end
    endtask

    initial begin
        start_up_n = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        test_reset();
        test_load_ok();
        test_bad_checksum();
        test_zero_len();
        test_too_long();
        test_gaps_abort();
        total++; if (consec_we != 0) begin bad++; $display("FAIL we_consecutive got=%0d exp=0", consec_we); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
